// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The state encoding is only ever used by name.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD
    } fetch_state_e;

    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps at most one imem request in flight,
// and fills the IF/ID register while obeying the hazard unit's stall and redirect flush.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_next,
    output logic [31:0] pc,
    output logic [31:0] pc_p4,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        stall,
    input  logic        flush,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pcp4
);

    fetch_state_e r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_skid;
    logic         r_discard;
    logic         r_ifid_valid;
    logic [31:0]  r_ifid_instr;
    logic [31:0]  r_ifid_pc;
    logic [31:0]  r_ifid_pcp4;

    logic [31:0]  w_pc_p4;
    logic         w_req_fire;
    logic         w_deliver;
    logic [31:0]  w_deliver_word;

    assign w_pc_p4    = r_pc + PC_INC;
    assign w_req_fire = imem_req_valid & imem_req_ready;

    // A word reaches IF/ID either straight from memory or from the skid buffer.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        w_deliver      = 1'b0;
        w_deliver_word = imem_rsp_data;
        if (!flush && !stall) begin
            case (r_state)
                ST_WAIT: w_deliver = imem_rsp_valid & ~r_discard;
                ST_HOLD: begin
                    w_deliver      = 1'b1;
                    w_deliver_word = r_skid;
                end
                default: w_deliver = 1'b0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_pc         <= RESET_PC;
            r_skid       <= '0;
            r_discard    <= 1'b0;
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= '0;
            r_ifid_pc    <= '0;
            r_ifid_pcp4  <= '0;
        end else begin
            if (flush) begin
                r_pc         <= pc_next;
                r_ifid_valid <= 1'b0;
            end else if (!stall) begin
                r_ifid_valid <= w_deliver;
                if (w_deliver) begin
                    r_ifid_instr <= w_deliver_word;
                    r_ifid_pc    <= r_pc;
                    r_ifid_pcp4  <= w_pc_p4;
                    r_pc         <= pc_next;
                end
            end

            case (r_state)
                ST_IDLE: r_state <= ST_REQ;
                ST_REQ: begin
                    if (w_req_fire) r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        r_discard <= 1'b0;
                        if (flush || r_discard || !stall) begin
                            r_state <= ST_REQ;
                        end else begin
                            r_skid  <= imem_rsp_data;
                            r_state <= ST_HOLD;
                        end
                    end else if (flush) begin
                        // The old response is still owed; remember to drop it.
                        r_discard <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (flush || !stall) r_state <= ST_REQ;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign pc             = r_pc;
    assign pc_p4          = w_pc_p4;
    assign imem_addr      = r_pc;
    assign imem_req_valid = (r_state == ST_REQ) && !flush;
    assign ifid_valid     = r_ifid_valid;
    assign ifid_instr     = r_ifid_instr;
    assign ifid_pc        = r_ifid_pc;
    assign ifid_pcp4      = r_ifid_pcp4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a memory that answers addr ^ 32'hA5A5_0000 after a
// programmable delay, a per-cycle transaction-level model, and literal spot checks.
module tb_fetch_unit;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_next;
    logic [31:0] pc;
    logic [31:0] pc_p4;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        stall;
    logic        flush;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pcp4;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory model controls, written by the stimulus process.
    int next_delay   = 1;
    bit stale_inject = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_next        (pc_next),
        .pc             (pc),
        .pc_p4          (pc_p4),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .stall          (stall),
        .flush          (flush),
        .ifid_valid     (ifid_valid),
        .ifid_instr     (ifid_instr),
        .ifid_pc        (ifid_pc),
        .ifid_pcp4      (ifid_pcp4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Next-PC selector stand-in: sequential pc+4 unless a redirect target is given.
    task automatic drive(input logic s, input logic f, input logic r,
                         input logic tgt_en, input logic [31:0] tgt);
        stall          = s;
        flush          = f;
        imem_req_ready = r;
        pc_next        = tgt_en ? tgt : pc + 32'd4;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Instruction memory: one request at a time, response after next_delay cycles.
    initial begin
        bit          outstanding = 0;
        logic [31:0] out_addr    = '0;
        int          count       = 0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                outstanding = 0;
            end else begin
                if (imem_rsp_valid) outstanding = 0;
                if (imem_req_valid && imem_req_ready) begin
                    check_bit("one_outstanding", outstanding, 1'b0);
                    outstanding = 1;
                    out_addr    = imem_addr;
                    count       = next_delay;
                end
            end
            @(negedge clk);
            #1;
            if (stale_inject) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = 32'hDEAD_BEEF;
                stale_inject   = 0;
            end else if (outstanding && rst_n) begin
                if (count > 0) count--;
                imem_rsp_valid = (count == 0);
                imem_rsp_data  = (count == 0) ? (out_addr ^ KEY) : 32'h0;
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'h0;
            end
        end
    end

    // Transaction-level model: PC moves only on delivery or flush; IF/ID follows stall/flush rules.
    initial begin
        logic [31:0] model_pc   = 32'h0;
        logic        prev_valid = 1'b0;
        logic [31:0] prev_instr = '0;
        logic [31:0] prev_pc    = '0;
        logic [31:0] prev_pcp4  = '0;
        logic        e_stall, e_flush;
        logic [31:0] e_pcn;
        forever begin
            @(posedge clk);
            e_stall = stall;
            e_flush = flush;
            e_pcn   = pc_next;
            #1;
            if (!rst_n) begin
                model_pc = 32'h0;
                check_bit("m_rst_valid", ifid_valid, 1'b0);
                check("m_rst_pc", pc, 32'h0);
            end else begin
                if (e_flush) begin
                    model_pc = e_pcn;
                    check_bit("m_flush_bubble", ifid_valid, 1'b0);
                end else if (e_stall) begin
                    check_bit("m_stall_valid", ifid_valid, prev_valid);
                    check("m_stall_instr", ifid_instr, prev_instr);
                    check("m_stall_pc", ifid_pc, prev_pc);
                end else if (ifid_valid) begin
                    check("m_dlv_pc", ifid_pc, model_pc);
                    check("m_dlv_instr", ifid_instr, model_pc ^ KEY);
                    check("m_dlv_pcp4", ifid_pcp4, model_pc + 32'd4);
                    model_pc = e_pcn;
                end else begin
                    check("m_bubble_instr", ifid_instr, prev_instr);
                    check("m_bubble_pc", ifid_pc, prev_pc);
                end
                check("m_pc", pc, model_pc);
            end
            check("m_addr", imem_addr, pc);
            check("m_pc_p4", pc_p4, pc + 32'd4);
            prev_valid = ifid_valid;
            prev_instr = ifid_instr;
            prev_pc    = ifid_pc;
            prev_pcp4  = ifid_pcp4;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
        repeat (3) tick();
        check("rst_pc", pc, 32'h0);
        check_bit("rst_valid", ifid_valid, 1'b0);
        check("rst_instr", ifid_instr, 32'h0);
        check("rst_ifid_pc", ifid_pc, 32'h0);
        check("rst_pcp4", ifid_pcp4, 32'h0);

        // Free run with zero-wait memory.
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        #1 check_bit("idle_no_req", imem_req_valid, 1'b0);
        tick();
        check_bit("first_req", imem_req_valid, 1'b1);
        check("first_addr", imem_addr, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        check_bit("wait_no_req", imem_req_valid, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        check_bit("d0_valid", ifid_valid, 1'b1);
        check("d0_pc", ifid_pc, 32'h0);
        check("d0_instr", ifid_instr, 32'hA5A5_0000);
        check("d0_pcp4", ifid_pcp4, 32'h4);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        check_bit("cadence_bubble", ifid_valid, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        check("d1_pc", ifid_pc, 32'h4);
        check("d1_instr", ifid_instr, 32'hA5A5_0004);
        check("pc_at_8", pc, 32'h8);

        // Memory backpressure for three cycles at 0x8.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_bit("bp_req_valid", imem_req_valid, 1'b1);
            check("bp_addr", imem_addr, 32'h8);
            check_bit("bp_no_ifid", ifid_valid, 1'b0);
            drive(1'b0, 1'b0, (i == 2), 1'b0, 32'h0);
        end
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        check("d2_pc", ifid_pc, 32'h8);
        check("d2_instr", ifid_instr, 32'hA5A5_0008);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        check("d3_pc", ifid_pc, 32'hC);

        // Stall when the 0x10 response lands.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        check("hold_ifid_pc", ifid_pc, 32'hC);
        check("hold_pc", pc, 32'h10);
        check_bit("hold_no_req", imem_req_valid, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        check("hold2_ifid_pc", ifid_pc, 32'hC);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        check_bit("unstall_valid", ifid_valid, 1'b1);
        check("unstall_ifid_pc", ifid_pc, 32'h10);
        check("unstall_instr", ifid_instr, 32'hA5A5_0010);
        check("unstall_pc", pc, 32'h14);

        // Flush in WAIT, stale response two cycles later.
        next_delay = 3;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h200);
        tick();
        check("flw_pc", pc, 32'h200);
        check_bit("flw_valid", ifid_valid, 1'b0);
        check_bit("flw_no_req", imem_req_valid, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        check_bit("flw_no_req2", imem_req_valid, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        check_bit("flw_dropped", ifid_valid, 1'b0);
        check_bit("flw_req", imem_req_valid, 1'b1);
        check("flw_addr", imem_addr, 32'h200);
        next_delay = 1;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        check("tgt_ifid_pc", ifid_pc, 32'h200);
        check("tgt_instr", ifid_instr, 32'hA5A5_0200);

        // Flush coinciding with the response.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h300);
        tick();
        check("flr_pc", pc, 32'h300);
        check_bit("flr_valid", ifid_valid, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        #1 check_bit("flr_req", imem_req_valid, 1'b1);
        check("flr_addr", imem_addr, 32'h300);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        check("flr_ifid_pc", ifid_pc, 32'h300);
        check("flr_instr", ifid_instr, 32'hA5A5_0300);

        // Flush together with stall while in HOLD.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        check("flh_hold_ifid_pc", ifid_pc, 32'h300);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h400);
        tick();
        check("flh_pc", pc, 32'h400);
        check_bit("flh_valid", ifid_valid, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        check("flh_ifid_pc", ifid_pc, 32'h400);
        check("flh_instr", ifid_instr, 32'hA5A5_0400);

        // Reset during WAIT, stale response right after release.
        next_delay = 5;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        check_bit("pre_rst_wait", imem_req_valid, 1'b0);
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        check("mid_rst_pc", pc, 32'h0);
        check_bit("mid_rst_valid", ifid_valid, 1'b0);
        next_delay   = 1;
        rst_n        = 1'b1;
        stale_inject = 1;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        #1 check_bit("re_idle_no_req", imem_req_valid, 1'b0);
        tick();
        check("re_pc", pc, 32'h0);
        check_bit("re_valid", ifid_valid, 1'b0);
        check_bit("re_req", imem_req_valid, 1'b1);
        check("re_addr", imem_addr, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        check_bit("re_d0_valid", ifid_valid, 1'b1);
        check("re_d0_pc", ifid_pc, 32'h0);
        check("re_d0_instr", ifid_instr, 32'hA5A5_0000);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
